// File: rtl/div_unit_if.sv
// Request/response handshake between issue/writeback and the divide unit.
interface div_unit_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [1:0]  op_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  modport master (
    output valid_i, a_i, b_i, op_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, a_i, b_i, op_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division on
// operand magnitudes, sign fixup on the final step, valid/ready result port.
module div_unit #(
  parameter bit EARLY_OUT = 1'b1
) (
  input logic       clk_i,
  input logic       rst_i,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] dq;        // dividend bits shift out the top, quotient bits in at the bottom
  logic [31:0] dvs;
  logic [31:0] spec_res;
  logic        spec;
  logic        op_rem;
  logic        neg_q;
  logic        neg_r;

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        in_spec;
  logic [31:0] in_spec_res;
  logic [32:0] trial;
  logic [31:0] rem_nx;
  logic [31:0] q_nx;
  logic [31:0] fin;

  always_comb begin
    is_signed   = ~bus.op_i[0];
    a_neg       = is_signed & bus.a_i[31];
    b_neg       = is_signed & bus.b_i[31];
    a_abs       = a_neg ? (32'd0 - bus.a_i) : bus.a_i;
    b_abs       = b_neg ? (32'd0 - bus.b_i) : bus.b_i;
    in_spec     = (bus.b_i == '0) |
                  (is_signed & (bus.a_i == 32'h8000_0000) & (bus.b_i == '1));
    if (bus.b_i == '0)
      in_spec_res = bus.op_i[1] ? bus.a_i : '1;
    else
      in_spec_res = bus.op_i[1] ? '0 : 32'h8000_0000;

    // Remainder stays below the divisor, so a non-borrowing difference fits 32 bits.
    trial  = {rem, dq[31]} - {1'b0, dvs};
    rem_nx = trial[32] ? {rem[30:0], dq[31]} : trial[31:0];
    q_nx   = {dq[30:0], ~trial[32]};

    if (spec)
      fin = spec_res;
    else if (op_rem)
      fin = neg_r ? (32'd0 - rem_nx) : rem_nx;
    else
      fin = neg_q ? (32'd0 - q_nx) : q_nx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      bus.valid_o  <= 1'b0;
      bus.result_o <= '0;
      bus.busy_o   <= 1'b0;
      bus.ready_o  <= 1'b1;
      cnt          <= '0;
      rem          <= '0;
      dq           <= '0;
      dvs          <= '0;
      spec_res     <= '0;
      spec         <= 1'b0;
      op_rem       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
    end else if (bus.kill_i) begin
      state       <= IDLE;
      bus.valid_o <= 1'b0;
      bus.busy_o  <= 1'b0;
      bus.ready_o <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.valid_i && bus.ready_o) begin
            op_rem      <= bus.op_i[1];
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            spec        <= in_spec;
            spec_res    <= in_spec_res;
            rem         <= '0;
            dq          <= a_abs;
            dvs         <= b_abs;
            cnt         <= 5'd31;
            bus.ready_o <= 1'b0;
            bus.busy_o  <= 1'b1;
            if (EARLY_OUT && in_spec) begin
              state        <= DONE;
              bus.valid_o  <= 1'b1;
              bus.result_o <= in_spec_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          dq  <= q_nx;
          cnt <= cnt - 5'd1;
          if (cnt == '0) begin
            state        <= DONE;
            bus.valid_o  <= 1'b1;
            bus.result_o <= fin;
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            state       <= IDLE;
            bus.valid_o <= 1'b0;
            bus.busy_o  <= 1'b0;
            bus.ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: one instance per EARLY_OUT setting, a vector table,
// random operations against an arithmetic model, and handshake/flush sequences.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sel;
  logic        v;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [1:0]  op_r;
  logic        kill_r;
  logic        rdy_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  div_unit_if if0 ();
  div_unit_if if1 ();

  assign if0.valid_i = v & ~sel;
  assign if1.valid_i = v & sel;
  assign if0.a_i     = a_r;
  assign if1.a_i     = a_r;
  assign if0.b_i     = b_r;
  assign if1.b_i     = b_r;
  assign if0.op_i    = op_r;
  assign if1.op_i    = op_r;
  assign if0.kill_i  = kill_r;
  assign if1.kill_i  = kill_r;
  assign if0.ready_i = rdy_r;
  assign if1.ready_i = rdy_r;

  div_unit #(.EARLY_OUT(1'b0)) dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(if0.slave));
  div_unit #(.EARLY_OUT(1'b1)) dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1.slave));

  logic        cur_valid;
  logic        cur_ready;
  logic        cur_busy;
  logic [31:0] cur_result;
  assign cur_valid  = sel ? if1.valid_o  : if0.valid_o;
  assign cur_ready  = sel ? if1.ready_o  : if0.ready_o;
  assign cur_busy   = sel ? if1.busy_o   : if0.busy_o;
  assign cur_result = sel ? if1.result_o : if0.result_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] op);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, output logic [31:0] res, output int lat);
    sel  = s;
    a_r  = a;
    b_r  = b;
    op_r = op;
    #0;
    chk("ready_before_accept", {31'd0, cur_ready}, 32'd1);
    v = 1'b1;
    @(posedge clk_i); #1;
    v   = 1'b0;
    lat = 1;
    while (!cur_valid && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    if (!cur_valid) chk("result_timeout", {31'd0, cur_valid}, 32'd1);
    res = cur_result;
  endtask

  task automatic xfer();
    rdy_r = 1'b1;
    @(posedge clk_i); #1;
    chk("xfer_valid_low", {31'd0, cur_valid}, 32'd0);
    chk("xfer_ready_high", {31'd0, cur_ready}, 32'd1);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [31:0] res;
    int          lat;
    int          bad;

    rst_i = 1'b1; sel = 1'b1; v = 1'b0; a_r = '0; b_r = '0; op_r = '0;
    kill_r = 1'b0; rdy_r = 1'b1;

    tbl[0]  = '{1'b1, 32'd100,        32'd7,          2'b00, 32'd14,         33};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          2'b10, 32'hFFFF_FFFF,  33};
    tbl[2]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          2'b00, 32'hFFFF_FFFD,  33};
    tbl[3]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          2'b11, 32'd1,          33};
    tbl[4]  = '{1'b1, 32'd5,          32'd0,          2'b01, 32'hFFFF_FFFF,  1};
    tbl[5]  = '{1'b1, 32'd5,          32'd0,          2'b11, 32'd5,          1};
    tbl[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  2'b00, 32'h8000_0000,  1};
    tbl[7]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  2'b10, 32'd0,          1};
    tbl[8]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          2'b00, 32'hFFFF_FFFF,  1};
    tbl[9]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          2'b10, 32'hFFFF_FFFB,  1};
    tbl[10] = '{1'b0, 32'd5,          32'd0,          2'b01, 32'hFFFF_FFFF,  33};
    tbl[11] = '{1'b0, 32'd5,          32'd0,          2'b11, 32'd5,          33};
    tbl[12] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  2'b00, 32'h8000_0000,  33};
    tbl[13] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  2'b10, 32'd0,          33};
    tbl[14] = '{1'b0, 32'hFFFF_FFFB,  32'd0,          2'b10, 32'hFFFF_FFFB,  33};
    tbl[15] = '{1'b0, 32'd100,        32'd7,          2'b00, 32'd14,         33};

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_valid0",  {31'd0, if0.valid_o}, 32'd0);
    chk("rst_ready0",  {31'd0, if0.ready_o}, 32'd1);
    chk("rst_busy1",   {31'd0, if1.busy_o},  32'd0);
    chk("rst_result1", if1.result_o,         32'd0);

    foreach (tbl[i]) begin
      do_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].op, res, lat);
      chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_busy", i), {31'd0, cur_busy}, 32'd1);
      xfer();
    end

    for (int i = 0; i < 40; i++) begin
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      s  = 1'($urandom);
      op = 2'($urandom);
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = 32'd0 - $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      do_op(s, a, b, op, res, lat);
      chk($sformatf("rnd%0d_result", i), res, model(a, b, op));
      chk($sformatf("rnd%0d_latency", i), lat, (s && is_special(a, b, op)) ? 1 : 33);
      xfer();
    end

    // Backpressure: result must hold while writeback stalls.
    rdy_r = 1'b0;
    do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 2'b01, res, lat);
    chk("bp_first", res, 32'hFFFF_FFFF);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      if (!cur_valid || cur_result !== 32'hFFFF_FFFF || cur_ready) bad++;
    end
    chk("bp_hold", bad, 0);
    xfer();

    // Flush mid-division, then an immediate new division.
    sel = 1'b1; a_r = 32'd1000; b_r = 32'd7; op_r = 2'b00; v = 1'b1;
    @(posedge clk_i); #1;
    v = 1'b0;
    bad = 0;
    for (int k = 1; k < 10; k++) begin
      if (cur_valid) bad++;
      @(posedge clk_i); #1;
    end
    kill_r = 1'b1;
    @(posedge clk_i); #1;
    kill_r = 1'b0;
    chk("kill_no_valid", bad, 0);
    chk("kill_valid_low", {31'd0, cur_valid}, 32'd0);
    chk("kill_ready", {31'd0, cur_ready}, 32'd1);
    chk("kill_busy", {31'd0, cur_busy}, 32'd0);
    do_op(1'b1, 32'd9, 32'd3, 2'b00, res, lat);
    chk("after_kill_result", res, 32'd3);
    chk("after_kill_latency", lat, 33);
    xfer();

    // Reset mid-division.
    a_r = 32'd1000; b_r = 32'd7; op_r = 2'b00; v = 1'b1;
    @(posedge clk_i); #1;
    v = 1'b0;
    repeat (19) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("midrst_valid", {31'd0, cur_valid}, 32'd0);
    chk("midrst_result", cur_result, 32'd0);
    chk("midrst_busy", {31'd0, cur_busy}, 32'd0);
    chk("midrst_ready", {31'd0, cur_ready}, 32'd1);
    bad = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (cur_valid) bad++;
    end
    chk("midrst_no_result", bad, 0);

    // Back-to-back with valid_i held high.
    sel = 1'b1; rdy_r = 1'b1;
    a_r = 32'd1000; b_r = 32'd10; op_r = 2'b01; v = 1'b1;
    @(posedge clk_i); #1;
    a_r = 32'd1000; b_r = 32'hFFFF_FFFD; op_r = 2'b10;
    lat = 1;
    while (!cur_valid && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("b2b_first_latency", lat, 33);
    chk("b2b_first_result", cur_result, 32'd100);
    @(posedge clk_i); #1;
    chk("b2b_gap_ready", {31'd0, cur_ready}, 32'd1);
    chk("b2b_gap_valid", {31'd0, cur_valid}, 32'd0);
    @(posedge clk_i); #1;
    v = 1'b0;
    chk("b2b_second_busy", {31'd0, cur_busy}, 32'd1);
    lat = 1;
    while (!cur_valid && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("b2b_second_latency", lat, 33);
    chk("b2b_second_result", cur_result, 32'd1);
    xfer();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
